// File: rtl/quick_rs232_pkg.sv
// Shared types and constants for the QuickRS232 oversampling receiver.
package quick_rs232_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'b00,
    PARITY_EVEN = 2'b01,
    PARITY_ODD  = 2'b10
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } rx_state_e;

  localparam int unsigned RX_ENTRY_W = 10;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/quick_rs232_fifo.sv
// First-word-fall-through FIFO; head is presented combinationally, zero when empty.
module quick_rs232_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_fill
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [FILL_W-1:0] r_fill;
  logic              w_pop;
  logic              w_push;

  assign o_empty = (r_fill == '0);
  assign o_full  = (r_fill == FILL_W'(DEPTH));
  assign o_fill  = r_fill;
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + FILL_W'(1);
        2'b01:   r_fill <= r_fill - FILL_W'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end

endmodule

// File: rtl/quick_rs232_rx_ovs.sv
// RS-232 receiver with runtime character format, 3-sample majority voting,
// error-tagged receive FIFO and FIFO-level-driven CTS.
module quick_rs232_rx_ovs
  import quick_rs232_pkg::*;
#(
  parameter int unsigned CLK_TICKS_PER_RS232_BIT = 434,
  parameter int unsigned FIFO_DEPTH              = 16,
  parameter int unsigned CTS_HEADROOM            = 4,
  parameter int unsigned FLOW_CONTROL            = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic [1:0]                    cfg_byte_len,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop_bits,
  output logic                          cts,
  input  logic                          rx_read,
  output logic                          rx_valid,
  output logic [7:0]                    rx_data,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  output logic                          rx_overrun,
  input  logic                          rx_overrun_clear,
  output logic [$clog2(FIFO_DEPTH):0]   rx_fill
);

  localparam int unsigned CNT_W  = $clog2(CLK_TICKS_PER_RS232_BIT);
  localparam int unsigned H      = CLK_TICKS_PER_RS232_BIT / 2;
  localparam int unsigned FILL_W = $clog2(FIFO_DEPTH) + 1;

  logic                  r_rx_s1, r_rx_s2, r_rx_prev;
  logic                  w_fall;
  rx_state_e             r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic                  w_wrap, w_mid;
  logic [2:0]            r_smp;
  logic                  w_maj;
  logic [1:0]            r_len;
  logic [1:0]            r_par;
  logic                  r_two_stop;
  logic [7:0]            r_data;
  logic [2:0]            r_bit_idx;
  logic                  r_perr, r_ferr;
  logic [2:0]            w_last_idx;
  logic                  w_par_en, w_par_exp;
  logic                  w_push;
  logic [RX_ENTRY_W-1:0] w_wr_entry, w_head;
  logic                  w_empty, w_full, w_rd_fire, w_drop;
  logic                  r_cts, r_overrun;

  // Two-flop synchroniser plus previous value for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  assign w_fall     = r_rx_prev & ~r_rx_s2;
  assign w_wrap     = (r_cnt == CNT_W'(CLK_TICKS_PER_RS232_BIT - 1));
  assign w_mid      = (r_cnt == CNT_W'(H + 2));
  assign w_maj      = maj3(r_smp);
  assign w_last_idx = 3'd4 + {1'b0, r_len};
  assign w_par_en   = (r_par == PARITY_EVEN) || (r_par == PARITY_ODD);
  assign w_par_exp  = (^r_data) ^ (r_par == PARITY_ODD);
  assign w_wr_entry = {r_ferr | ~w_maj, r_perr, r_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    case (r_state)
      IDLE:   if (w_fall) w_state_nxt = START;
      START: begin
        if (w_mid && w_maj) w_state_nxt = IDLE;
        else if (w_wrap)    w_state_nxt = DATA;
      end
      DATA: begin
        if (w_wrap && (r_bit_idx == w_last_idx))
          w_state_nxt = w_par_en ? PARITY : STOP1;
      end
      PARITY: if (w_wrap) w_state_nxt = STOP1;
      STOP1: begin
        if (r_two_stop) begin
          if (w_wrap) w_state_nxt = STOP2;
        end else if (w_mid) begin
          w_push      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      STOP2: begin
        if (w_mid) begin
          w_push      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bit-time counter; held at zero while idle so START begins at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          r_cnt <= '0;
    else if (r_state == IDLE || w_state_nxt == IDLE)  r_cnt <= '0;
    else if (w_wrap)                                  r_cnt <= '0;
    else                                              r_cnt <= r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_smp <= 3'b111;
    end else begin
      if (r_cnt == CNT_W'(H - 1)) r_smp[0] <= r_rx_s2;
      if (r_cnt == CNT_W'(H))     r_smp[1] <= r_rx_s2;
      if (r_cnt == CNT_W'(H + 1)) r_smp[2] <= r_rx_s2;
    end
  end

  // Character assembly; format is frozen when the start edge is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len      <= '0;
      r_par      <= '0;
      r_two_stop <= 1'b0;
      r_data     <= '0;
      r_bit_idx  <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_len      <= cfg_byte_len;
            r_par      <= cfg_parity;
            r_two_stop <= cfg_stop_bits;
            r_data     <= '0;
            r_bit_idx  <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
          end
        end
        DATA: begin
          if (w_mid)  r_data[r_bit_idx] <= w_maj;
          if (w_wrap) r_bit_idx <= r_bit_idx + 3'd1;
        end
        PARITY:       if (w_mid && (w_maj != w_par_exp)) r_perr <= 1'b1;
        STOP1, STOP2: if (w_mid && !w_maj) r_ferr <= 1'b1;
        default: ;
      endcase
    end
  end

  quick_rs232_fifo #(
    .WIDTH (RX_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (rx_read),
    .i_wdata (w_wr_entry),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_fill  (rx_fill)
  );

  assign w_rd_fire = rx_read & ~w_empty;
  assign w_drop    = w_push & w_full & ~w_rd_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cts     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_cts <= (FLOW_CONTROL == 0) ? 1'b1
             : (rx_fill < FILL_W'(FIFO_DEPTH - CTS_HEADROOM));
      if (w_drop)                r_overrun <= 1'b1;
      else if (rx_overrun_clear) r_overrun <= 1'b0;
    end
  end

  assign cts           = r_cts;
  assign rx_overrun    = r_overrun;
  assign rx_valid      = ~w_empty;
  assign rx_data       = w_head[7:0];
  assign rx_parity_err = w_head[8];
  assign rx_frame_err  = w_head[9];

endmodule

// File: tb/tb_quick_rs232_rx_ovs.sv
// Scoreboard bench for quick_rs232_rx_ovs: serialised characters vs a frame-level model.
module tb_quick_rs232_rx_ovs;

  localparam int TICKS = 16;
  localparam int DEPTH = 4;
  localparam int HEAD  = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic [1:0] cfg_byte_len = 2'd3;
  logic [1:0] cfg_parity = 2'd0;
  logic       cfg_stop_bits = 1'b0;
  logic       cts;
  logic       rx_read = 1'b0;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_frame_err;
  logic       rx_parity_err;
  logic       rx_overrun;
  logic       rx_overrun_clear = 1'b0;
  logic [2:0] rx_fill;

  int checks = 0;
  int errors = 0;
  logic [9:0] sb[$];

  quick_rs232_rx_ovs #(
    .CLK_TICKS_PER_RS232_BIT (TICKS),
    .FIFO_DEPTH              (DEPTH),
    .CTS_HEADROOM            (HEAD),
    .FLOW_CONTROL            (1)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .rx               (rx),
    .cfg_byte_len     (cfg_byte_len),
    .cfg_parity       (cfg_parity),
    .cfg_stop_bits    (cfg_stop_bits),
    .cts              (cts),
    .rx_read          (rx_read),
    .rx_valid         (rx_valid),
    .rx_data          (rx_data),
    .rx_frame_err     (rx_frame_err),
    .rx_parity_err    (rx_parity_err),
    .rx_overrun       (rx_overrun),
    .rx_overrun_clear (rx_overrun_clear),
    .rx_fill          (rx_fill)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted read is compared with the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && rx_valid && rx_read) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow actual=%0h required=none", {rx_frame_err, rx_parity_err, rx_data});
      end else begin
        check("rx_entry", {22'd0, rx_frame_err, rx_parity_err, rx_data}, {22'd0, sb.pop_front()});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    tick(n);
  endtask

  task automatic check_reset_values();
    check("rst_cts", {31'd0, cts}, 0);
    check("rst_valid", {31'd0, rx_valid}, 0);
    check("rst_data", {24'd0, rx_data}, 0);
    check("rst_errs", {30'd0, rx_frame_err, rx_parity_err}, 0);
    check("rst_ovr", {31'd0, rx_overrun}, 0);
    check("rst_fill", {29'd0, rx_fill}, 0);
  endtask

  // Serialises one character; rst_bit >= 0 aborts with a reset at that frame bit.
  task automatic send_char(input logic [7:0] d, input int len, input int par, input bit two,
                           input bit pflip, input bit [1:0] sbad, input int glitch_bit,
                           input bit pop_at_push, input int rst_bit);
    bit   frame[$];
    int   nb;
    bit   par_en;
    bit   pbit;
    logic [7:0] dm;
    nb     = 5 + len;
    dm     = d & 8'((1 << nb) - 1);
    par_en = (par == 1) || (par == 2);
    pbit   = (($countones(dm) % 2) == 1) ^ (par == 2) ^ pflip;
    frame.push_back(1'b0);
    for (int i = 0; i < nb; i++) frame.push_back(dm[i]);
    if (par_en) frame.push_back(pbit);
    frame.push_back(~sbad[0]);
    if (two) frame.push_back(~sbad[1]);
    cfg_byte_len  = 2'(len);
    cfg_parity    = 2'(par);
    cfg_stop_bits = two;
    for (int b = 0; b < frame.size(); b++) begin
      for (int j = 0; j < TICKS; j++) begin
        if (b == rst_bit && j == 8) begin
          rst = 1'b1;
          rx = 1'b1;
          rx_read = 1'b0;
          tick(3);
          check_reset_values();
          sb.delete();
          rst = 1'b0;
          tick(1);
          check("cts_after_rst", {31'd0, cts}, 1);
          return;
        end
        rx = (b == glitch_bit && j == 8) ? ~frame[b] : frame[b];
        rx_read = pop_at_push && (b == frame.size() - 1) && (j == 13);
        tick(1);
      end
    end
    rx = 1'b1;
    rx_read = 1'b0;
    if (sb.size() < DEPTH)
      sb.push_back({sbad[0] | (two & sbad[1]), par_en & pflip, dm});
  endtask

  task automatic drain();
    int n;
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      rx_read = 1'b1;
      tick(1);
    end
    rx_read = 1'b0;
    tick(1);
    check("drain_sb_empty", sb.size(), 0);
    check("drain_valid", {31'd0, rx_valid}, 0);
    check("drain_fill", {29'd0, rx_fill}, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    check_reset_values();
    rst = 1'b0;
    tick(1);
    check("cts_release", {31'd0, cts}, 1);
    idle(4);

    // 8E1 0x53, correct parity bit is 0
    send_char(8'h53, 3, 1, 1'b0, 1'b0, 2'b00, -1, 1'b0, -1);
    idle(4);
    check("e1_valid", {31'd0, rx_valid}, 1);
    check("e1_fill", {29'd0, rx_fill}, 1);
    check("e1_data", {24'd0, rx_data}, 32'h53);
    drain();

    // 5O2 with wrong parity, then 5O2 with bad second stop bit
    send_char(8'h14, 0, 2, 1'b1, 1'b1, 2'b00, -1, 1'b0, -1);
    idle(4);
    check("o2_perr", {31'd0, rx_parity_err}, 1);
    check("o2_data", {24'd0, rx_data}, 32'h14);
    send_char(8'h0B, 0, 2, 1'b1, 1'b0, 2'b10, -1, 1'b0, -1);
    idle(4);
    drain();

    // false start then glitched data bit 2
    rx = 1'b0;
    tick(3);
    idle(40);
    check("glitch_fill", {29'd0, rx_fill}, 0);
    send_char(8'h94, 3, 0, 1'b0, 1'b0, 2'b00, 3, 1'b0, -1);
    idle(4);
    check("g_data", {24'd0, rx_data}, 32'h94);
    drain();

    // randomised formats and error injections
    for (int it = 0; it < 10; it++) begin
      send_char(8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : -1, 1'b0, -1);
      idle(int'($urandom_range(3, 9)));
      if (it % 2 == 1) drain();
    end

    // overrun and cts behaviour
    for (int c = 1; c <= 5; c++) begin
      send_char(8'(c), 3, 0, 1'b0, 1'b0, 2'b00, -1, 1'b0, -1);
      idle(4);
      check("ovr_fill", {29'd0, rx_fill}, (c < DEPTH) ? c : DEPTH);
      check("ovr_cts", {31'd0, cts}, (((c < DEPTH) ? c : DEPTH) < DEPTH - HEAD) ? 1 : 0);
      check("ovr_flag", {31'd0, rx_overrun}, (c == 5) ? 1 : 0);
    end
    rx_overrun_clear = 1'b1;
    tick(1);
    rx_overrun_clear = 1'b0;
    check("ovr_clear", {31'd0, rx_overrun}, 0);

    // push while full with a simultaneous pop
    send_char(8'h06, 3, 0, 1'b0, 1'b0, 2'b00, -1, 1'b1, -1);
    idle(4);
    check("coll_fill", {29'd0, rx_fill}, DEPTH);
    check("coll_ovr", {31'd0, rx_overrun}, 0);
    check("coll_head", {24'd0, rx_data}, 32'h02);
    drain();

    // reset during data bit 4 with a character already queued
    send_char(8'h3C, 3, 0, 1'b0, 1'b0, 2'b00, -1, 1'b0, -1);
    idle(4);
    send_char(8'h77, 3, 0, 1'b0, 1'b0, 2'b00, -1, 1'b0, 5);
    idle(20);
    check("post_rst_fill", {29'd0, rx_fill}, 0);
    send_char(8'hA5, 3, 0, 1'b0, 1'b0, 2'b00, -1, 1'b0, -1);
    idle(4);
    check("a5_data", {24'd0, rx_data}, 32'hA5);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/quick_rs232_rx_ovs.md
# quick_rs232_rx_ovs

Next-generation RS-232 receiver for the QuickRS232 core, generalised over the fixed-format receiver. Character format is runtime-selectable: 5–8 data bits, none/even/odd parity, 1 or 2 stop bits. Each bit is recovered by a 3-sample majority vote at mid-bit, and the start bit is validated the same way. Received characters go into a parametrised FIFO with per-character error tags, and the block drives CTS flow control from the FIFO fill level. It sits between the rx pin and the host-side read logic, alongside the existing transmitter.

## Interface
- CLK_TICKS_PER_RS232_BIT, 434, clk cycles per bit; minimum 8 (434 gives 115200 bit/s at 50 MHz)
- FIFO_DEPTH, 16, FIFO entries; power of 2, minimum 4
- CTS_HEADROOM, 4, free entries below which cts drops; range 1..FIFO_DEPTH-1
- FLOW_CONTROL, 1, 1 = cts follows FIFO level; 0 = cts held 1 outside reset

Ports (clock and reset first):
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- rx  in  1  serial line, asynchronous; idle level 1
- cfg_byte_len  in  2  data bits = 5 + value
- cfg_parity  in  2  00 none, 01 even, 10 odd, 11 treated as none
- cfg_stop_bits  in  1  0 = one stop bit, 1 = two stop bits
- cts  out  1  clear-to-send toward the remote sender
- rx_read  in  1  pop the FIFO head
- rx_valid  out  1  FIFO not empty; head is presented
- rx_data  out  8  head data, LSB-aligned, unused upper bits 0
- rx_frame_err  out  1  head character had a stop bit sampled 0
- rx_parity_err  out  1  head character failed the parity check
- rx_overrun  out  1  sticky; a character was dropped because the FIFO was full
- rx_overrun_clear  in  1  clears rx_overrun
- rx_fill  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

## Operation
- rx passes through a 2-FF synchroniser; both flops reset to 1.
- Bit counter runs 0..CLK_TICKS_PER_RS232_BIT-1. Let H = CLK_TICKS_PER_RS232_BIT/2, using integer division.
- Samples are taken at counter H-1, H and H+1. The bit value is the majority of the three and is valid at counter H+2.
- Configuration is latched on entry to START. Changes mid-frame have no effect on the frame in progress.
- State machine:
  - IDLE → START on a synchronised 1→0 transition; counter is cleared.
  - START: majority 1 → IDLE (false start, nothing recorded). Otherwise, at counter wrap → DATA.
  - DATA: shifts bits LSB-first. After bit (5+len-1) wraps, go to PARITY if parity is enabled, else STOP1.
  - PARITY: compares the sample against the computed parity (even: XOR of data bits; odd: its inverse). Mismatch sets the character's parity_err. Wrap → STOP1.
  - STOP1: majority 0 sets frame_err. If two stop bits, wrap → STOP2. Otherwise push at counter H+2 and go to IDLE in the same cycle.
  - STOP2: same as STOP1, then push and go to IDLE.
- Push writes {frame_err, parity_err, data} to the FIFO. Characters with errors are still pushed.
- Push when the FIFO is full and no pop happens in that cycle: character is dropped and rx_overrun is set.
- rx_read while rx_valid is low is ignored.
- cts (registered) = 1 when rx_fill < FIFO_DEPTH - CTS_HEADROOM, otherwise 0.

## Timing
- Reset values:
  - cts = 0
  - rx_valid = 0
  - rx_data = 0
  - rx_frame_err = 0
  - rx_parity_err = 0
  - rx_overrun = 0
  - rx_fill = 0
  - FSM in IDLE
- cts reaches its level-based value one cycle after rst falls.
- Line to detection: 2 cycles of synchroniser latency plus 1 cycle of edge detection.
- Push to visibility: rx_valid and the head fields are valid on the cycle after the push cycle (first-word-fall-through).
- Pop: rx_read sampled high with rx_valid=1 advances the head. The new head, or rx_valid=0, appears on the next cycle.
- Simultaneous push and pop:
  - When full: both succeed, fill is unchanged, no overrun.
  - When empty: the push succeeds and the pop is ignored.
- rx_overrun_clear and a new overrun in the same cycle: overrun wins.
- Read/write pointers wrap modulo FIFO_DEPTH. Fill is tracked with a separate counter.
- rst asserted mid-frame:
  - FSM returns to IDLE and the FIFO is emptied.
  - The partial character is discarded.
  - After release, the receiver waits for a fresh 1→0 edge.

## Structure
- Package quick_rs232_pkg:
  - parity encodings PARITY_NONE/EVEN/ODD
  - FSM state enum IDLE/START/DATA/PARITY/STOP1/STOP2
  - entry width constant RX_ENTRY_W = 10
- Sub-module quick_rs232_fifo:
  - synchronous FWFT FIFO, parameters WIDTH and DEPTH
  - outputs empty, full and fill
  - asynchronous active-high reset
- Top level contains the synchroniser, bit counter, majority voter, FSM and the cts/overrun logic.

## Test plan
Bench settings: CLK_TICKS_PER_RS232_BIT = 16, FIFO_DEPTH = 4, CTS_HEADROOM = 1.

- **8E1 character:** 0x53 sent with parity bit 0, no reads → rx_valid=1, rx_data=0x53, both error flags 0. After rx_read: rx_valid=0, rx_fill=0.
- **Errors and 5O2:**
  - 5O2, data 0x14 with a wrong parity bit → rx_data=0x14, rx_parity_err=1.
  - Next character with the second stop bit driven 0 → rx_frame_err=1.
- **Glitch rejection:**
  - rx low for 3 cycles, then high → no push, FSM back in IDLE.
  - A 1-cycle inverted glitch at mid-bit of data bit 2 of 0x94 → rx_data=0x94.
- **Overrun:**
  - 5 characters 0x01..0x05, no reads → cts falls once rx_fill=3, rx_fill=4, rx_overrun=1, FIFO holds 0x01..0x04.
  - rx_overrun_clear → rx_overrun=0.
- **Full with push/pop collision:** FIFO full, rx_read asserted in the push cycle of 0x06 → no overrun, fill stays 4, head becomes 0x02.
- **Reset mid-frame:** rst pulsed during data bit 4 → all outputs at reset values. The next clean 0xA5 (8N1) is received correctly.
